// File: rtl/ofdm_pkg.sv
// ofdm_pkg: shared FSM state type and default widths for the preamble generator
package ofdm_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;
  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 8;
endpackage

// File: rtl/ofdm_skid_fifo.sv
// ofdm_skid_fifo: 2-entry output buffer; data reads as zero while empty
module ofdm_skid_fifo #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_i,
  input  logic [W-1:0] din_i,
  input  logic         rd_i,
  output logic [W-1:0] dout_o,
  output logic         valid_o,
  output logic [1:0]   count_o
);
  logic [W-1:0] mem_q [2];
  logic         wp_q, rp_q;
  logic [1:0]   cnt_q;
  logic         pop;
  assign pop     = rd_i && cnt_q != 2'd0;
  assign valid_o = cnt_q != 2'd0;
  assign dout_o  = valid_o ? mem_q[rp_q] : '0;
  assign count_o = cnt_q;
  always_ff @(posedge clk) begin
    if (wr_i) mem_q[wp_q] <= din_i;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q  <= 1'b0;
      rp_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      wp_q  <= wp_q ^ wr_i;
      rp_q  <= rp_q ^ pop;
      cnt_q <= cnt_q + 2'(wr_i) - 2'(pop);
    end
  end
endmodule

// File: rtl/ofdm_preamble_gen.sv
// ofdm_preamble_gen: streams len_eff table samples reps_eff times from an external registered ROM
module ofdm_preamble_gen import ofdm_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] len,
  input  logic [3:0]        reps,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_i,
  input  logic [DATA_W-1:0] rom_q,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_i,
  output logic [DATA_W-1:0] m_q,
  output logic              m_first,
  output logic              m_last
);
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [3:0]        pass_q, pass_d, rmax_q, rmax_d;
  logic              pend_q, pf_q, pl_q, done_q;
  logic [1:0]        cnt;
  logic              pop, issue, wrap, is_first, is_last, fin;
  assign pop      = m_valid && m_ready;
  assign wrap     = ({1'b0, addr_q} + (ADDR_W+1)'(1)) == len_q;
  assign is_first = addr_q == '0 && pass_q == '0;
  assign is_last  = wrap && pass_q == rmax_q;
  // counting this cycle's pop as a free slot keeps the stream bubble-free at full rate
  assign issue    = state_q == RUN && (cnt + 2'(pend_q) - 2'(pop)) < 2'd2;
  assign fin      = state_q == DRAIN && pop && m_last;
  assign busy     = state_q != IDLE;
  assign done     = done_q;
  assign rom_addr = addr_q;
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    pass_d  = pass_q;
    rmax_d  = rmax_q;
    if (state_q == IDLE && start) begin
      state_d = RUN;
      addr_d  = '0;
      pass_d  = '0;
      len_d   = {~|len, len};
      rmax_d  = reps == 4'd0 ? 4'd0 : reps - 4'd1;
    end
    if (issue) begin
      addr_d  = wrap ? '0 : addr_q + ADDR_W'(1);
      pass_d  = pass_q + 4'(wrap);
      state_d = is_last ? DRAIN : RUN;
    end
    if (fin) state_d = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      pass_q  <= '0;
      rmax_q  <= '0;
      pend_q  <= 1'b0;
      pf_q    <= 1'b0;
      pl_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      pass_q  <= pass_d;
      rmax_q  <= rmax_d;
      pend_q  <= issue;
      pf_q    <= issue && is_first;
      pl_q    <= issue && is_last;
      done_q  <= fin;
    end
  end
  ofdm_skid_fifo #(.W(2*DATA_W+2)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_i    (pend_q),
    .din_i   ({rom_i, rom_q, pf_q, pl_q}),
    .rd_i    (m_ready),
    .dout_o  ({m_i, m_q, m_first, m_last}),
    .valid_o (m_valid),
    .count_o (cnt)
  );
endmodule

// File: tb/tb_ofdm_preamble_gen.sv
// tb_ofdm_preamble_gen: table-driven bursts with a scoreboard queue plus reset/restart corner sequences
module tb_ofdm_preamble_gen;
  localparam int DW = 16;
  localparam int AW = 8;
  logic          clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [AW-1:0] len = '0;
  logic [3:0]    reps = '0;
  logic          busy, done, m_valid, m_first, m_last;
  logic          m_ready = 1'b1;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_i = '0, rom_q = '0, m_i, m_q;
  typedef struct packed {logic [DW-1:0] i; logic [DW-1:0] q; logic f; logic l;} smp_t;
  typedef struct {int l; int r; bit mode;} vec_t;
  smp_t sbq[$];
  int   ncheck = 0, nfail = 0, ntx = 0;
  bit   rmode = 1'b0;

  ofdm_preamble_gen #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .reps(reps),
    .busy(busy), .done(done), .rom_addr(rom_addr), .rom_i(rom_i), .rom_q(rom_q),
    .m_valid(m_valid), .m_ready(m_ready), .m_i(m_i), .m_q(m_q),
    .m_first(m_first), .m_last(m_last)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] fi(logic [AW-1:0] a);
    return {8'hC3, a};
  endfunction
  function automatic logic [DW-1:0] fq(logic [AW-1:0] a);
    return {a ^ 8'h5A, ~a};
  endfunction

  always @(posedge clk) begin
    rom_i <= fi(rom_addr);
    rom_q <= fq(rom_addr);
  end

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    ncheck++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(int l, int r);
    int le = l == 0 ? 256 : l;
    int re = r == 0 ? 1 : r;
    for (int p = 0; p < re; p++)
      for (int a = 0; a < le; a++)
        sbq.push_back('{fi(AW'(a)), fq(AW'(a)), p == 0 && a == 0, p == re-1 && a == le-1});
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    m_ready = rmode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  initial begin
    smp_t prev, cur;
    bit   stall = 1'b0;
    forever begin
      @(negedge clk);
      cur = '{m_i, m_q, m_first, m_last};
      if (rst) stall = 1'b0;
      else begin
        if (stall) chk("hold_stable", {m_valid, cur}, {1'b1, prev});
        if (m_valid && m_ready) begin
          ntx++;
          if (sbq.size() == 0) chk("extra_transfer", 1'(m_valid && m_ready), 1'b0);
          else chk("sample", cur, sbq.pop_front());
        end
        stall = m_valid && !m_ready;
        prev  = cur;
      end
    end
  end

  task automatic wait_done(output int bc, output int fv, output bit seen);
    int cyc = 0;
    bc = 0; fv = -1; seen = 1'b0;
    while (!seen && cyc < 3000) begin
      @(negedge clk);
      if (busy) bc++;
      if (m_valid && fv < 0) fv = cyc;
      seen = done;
      cyc++;
    end
  endtask

  task automatic run(int l, int r, bit mode);
    int n = (l == 0 ? 256 : l) * (r == 0 ? 1 : r);
    int bc, fv;
    bit seen;
    rmode = mode;
    @(posedge clk); #1;
    start = 1'b1; len = AW'(l); reps = 4'(r);
    push(l, r);
    ntx = 0;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(bc, fv, seen);
    chk("done_seen", seen, 1'b1);
    chk("count", ntx, n);
    chk("sb_empty", sbq.size(), 0);
    if (!mode) begin
      chk("busy_cycles", bc, n + 2);
      chk("first_latency", fv, 2);
    end
    @(negedge clk);
    chk("done_pulse", done, 1'b0);
  endtask

  initial begin
    vec_t tv[6];
    int   bc, fv, dn;
    bit   seen;
    tv = '{'{4, 1, 1'b0}, '{8, 1, 1'b1}, '{0, 2, 1'b0}, '{1, 0, 1'b0}, '{3, 3, 1'b1}, '{2, 15, 1'b0}};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {m_valid, busy, done, m_first, m_last, rom_addr, m_i, m_q}, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 6; k++) run(tv[k].l, tv[k].r, tv[k].mode);

    // start while busy is ignored, then a start on the done cycle is accepted
    rmode = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; len = 8'd8; reps = 4'd1;
    push(8, 1);
    ntx = 0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1; len = 8'd5;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(bc, fv, seen);
    chk("busy_start_done", seen, 1'b1);
    chk("busy_start_count", ntx, 8);
    start = 1'b1; len = 8'd3; reps = 4'd2;
    push(3, 2);
    ntx = 0;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(bc, fv, seen);
    chk("chain_done", seen, 1'b1);
    chk("chain_count", ntx, 6);
    chk("chain_sb_empty", sbq.size(), 0);

    // reset mid-burst aborts with no done, then a normal burst follows
    rmode = 1'b1;
    @(posedge clk); #1;
    start = 1'b1; len = 8'd0; reps = 4'd1;
    push(0, 1);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    sbq.delete();
    dn = 0;
    repeat (3) begin
      @(negedge clk);
      dn += int'(done);
    end
    chk("midrst_outputs", {m_valid, busy, done, m_first, m_last, rom_addr, m_i, m_q}, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      dn += int'(done | m_valid | busy);
    end
    chk("midrst_quiet", dn, 0);
    run(4, 1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", ncheck, nfail);
    $finish;
  end
endmodule

// File: doc/ofdm_preamble_gen.md
OFDM_PREAMBLE_GEN -- requirements
Module: ofdm_preamble_gen

Interface
REQ-001 Parameter DATA_W, default 16: I and Q sample width.
REQ-002 Parameter ADDR_W, default 8: preamble table address width; table depth 2**ADDR_W.
REQ-003 clk  input  1  single clock; all logic on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  one-cycle request to begin a burst; sampled only in IDLE.
REQ-006 len  input  ADDR_W  samples per pass; 0 means 2**ADDR_W; captured on accepted start.
REQ-007 reps  input  4  number of passes; 0 treated as 1; captured on accepted start.
REQ-008 busy  output  1  high from accepted start until the final sample is transferred.
REQ-009 done  output  1  one-cycle pulse on the cycle after the final sample is transferred.
REQ-010 rom_addr  output  ADDR_W  read address to the preamble table.
REQ-011 rom_i, rom_q  input  DATA_W each  table data, valid exactly 1 cycle after rom_addr (registered read).
REQ-012 m_valid / m_ready  output / input  1 each  output stream handshake; transfer when both high.
REQ-013 m_i, m_q  output  DATA_W each  sample data.
REQ-014 m_first, m_last  output  1 each  mark the first sample of the burst and the final sample of the final pass.

Function
REQ-015 FSM states: IDLE, RUN, DRAIN; start in IDLE -> RUN; all reads issued -> DRAIN; buffer empty after final transfer -> IDLE.
REQ-016 In RUN, a read is issued only if the occupancy of the 2-entry output buffer plus reads in flight is below 2; each issued read increments rom_addr.
REQ-017 rom_addr wraps from len-1 to 0 at the end of a pass; pass counter increments; no read after pass reps, address len-1.
REQ-018 ROM data is written into the 2-entry FIFO on the cycle after the read issue, with first/last flags carried alongside.
REQ-019 m_valid is high whenever the FIFO is non-empty; m_i/m_q/m_first/m_last are stable while m_valid is high and m_ready is low.
REQ-020 First m_valid is asserted on the 2nd rising edge after the edge that sampled start; with m_ready held high, one sample is transferred per cycle with no bubbles.
REQ-021 Total samples transferred equal len_eff*reps_eff; the sample sequence is address 0..len_eff-1 repeated reps_eff times.
REQ-022 m_first is high only on the first sample of pass 1; m_last is high only on the final sample of the final pass.
REQ-023 A start while busy is ignored; a start on the done cycle is accepted (IDLE already entered).
REQ-024 Counters are sized so len_eff = 2**ADDR_W causes no overflow (ADDR_W+1 bits).

Reset
REQ-025 Under rst the state is IDLE; FIFO is empty; m_valid, busy, done, m_first, m_last, rom_addr, m_i, m_q are 0.
REQ-026 rst asserted mid-burst aborts on the next edge; no further transfers occur and no done pulse is generated.

Structure
REQ-027 A shared ofdm_pkg holds the FSM state enum and the default DATA_W/ADDR_W constants.
REQ-028 The 2-entry output FIFO is a sub-module, ofdm_skid_fifo, parameterised on width.
REQ-029 The preamble table is external; this block only drives rom_addr and consumes rom_i/rom_q.

Verification
REQ-030 Reset: hold rst 3 cycles mid-stream -> all outputs 0, no done pulse, IDLE; a following start works normally.
REQ-031 len=4, reps=1, m_ready=1: samples at addr 0,1,2,3 on 4 consecutive cycles starting 2 cycles after start; m_first on addr 0; m_last on addr 3; done on the next cycle.
REQ-032 len=8, reps=1, m_ready toggling pseudo-randomly: exactly 8 transfers, in order, none duplicated or dropped; data held stable while stalled.
REQ-033 len=0, reps=2: 512 transfers, address 255 followed by 0; m_last only on the 512th transfer.
REQ-034 start pulsed during busy: ignored, sample count unchanged; start on the done cycle: a new burst begins.
REQ-035 reps=0, len=1: single transfer with m_first=m_last=1, busy high for 3 cycles.
